// File: rtl/matmul_bram_loader.sv
// rtl/matmul_bram_loader.sv - port-A BRAM loader for the matmul core (option: MATLOAD_WEIGHT_RETAIN_EN)
module matmul_bram_loader #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 2,
    parameter int W_WORDS    = 6,
    parameter int I_WORDS    = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    go,
`ifdef MATLOAD_WEIGHT_RETAIN_EN
    input  logic                                    keep_w,
`endif
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [WIDTH*CHUNK_SIZE-1:0]             s_data,
    input  logic                                    s_last,
    output logic                                    wb_ena,
    output logic [7:0]                              wb_wea,
    output logic [11:0]                             wb_addra,
    output logic [WIDTH*CHUNK_SIZE-1:0]             wb_dina,
    output logic                                    in_ena,
    output logic [7:0]                              in_wea,
    output logic [13:0]                             in_addra,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]   in_dina,
    output logic                                    start,
    input  logic                                    core_done,
    output logic                                    busy,
    output logic                                    load_done,
    output logic                                    err_len
);
    localparam int BW  = WIDTH * CHUNK_SIZE;
    localparam int IW  = BW * NUM_CORES;
    localparam int BCW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, RUN, FIN} state_t;

    state_t          state;
    logic [11:0]     w_cnt;
    logic [13:0]     word_cnt;
    logic [BCW-1:0]  beat_cnt;
    logic [IW-1:0]   pack;
    logic [IW-1:0]   pack_next;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
    logic            w_loaded;
`endif

    logic accept;
    logic word_full;
    logic final_beat;

    assign s_ready    = (state == LOAD_W) || (state == LOAD_I);
    assign busy       = (state != IDLE);
    assign accept     = s_valid && s_ready;
    assign word_full  = (beat_cnt == BCW'(NUM_CORES - 1));
    assign final_beat = (state == LOAD_I) && word_full && (word_cnt == 14'(I_WORDS - 1));

    // First beat of a word lands in the LSBs
    always_comb begin
        pack_next = pack;
        pack_next[beat_cnt*BW +: BW] = s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            w_cnt     <= '0;
            word_cnt  <= '0;
            beat_cnt  <= '0;
            pack      <= '0;
            wb_ena    <= 1'b0;
            wb_wea    <= '0;
            wb_addra  <= '0;
            wb_dina   <= '0;
            in_ena    <= 1'b0;
            in_wea    <= '0;
            in_addra  <= '0;
            in_dina   <= '0;
            start     <= 1'b0;
            load_done <= 1'b0;
            err_len   <= 1'b0;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
            w_loaded  <= 1'b0;
`endif
        end else begin
            wb_ena    <= 1'b0;
            wb_wea    <= '0;
            in_ena    <= 1'b0;
            in_wea    <= '0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        err_len  <= 1'b0;
                        w_cnt    <= '0;
                        word_cnt <= '0;
                        beat_cnt <= '0;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
                        state    <= (keep_w && w_loaded) ? LOAD_I : LOAD_W;
`else
                        state    <= LOAD_W;
`endif
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        wb_ena   <= 1'b1;
                        wb_wea   <= 8'hFF;
                        wb_addra <= w_cnt;
                        wb_dina  <= s_data;
                        w_cnt    <= w_cnt + 12'd1;
                        if (s_last) begin
                            err_len <= 1'b1;
                            state   <= IDLE;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
                            w_loaded <= 1'b0;
`endif
                        end else if (w_cnt == 12'(W_WORDS - 1)) begin
                            state <= LOAD_I;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
                            w_loaded <= 1'b1;
`endif
                        end
                    end
                end
                LOAD_I: begin
                    if (accept) begin
                        pack <= pack_next;
                        if (word_full) begin
                            beat_cnt <= '0;
                            in_ena   <= 1'b1;
                            in_wea   <= 8'hFF;
                            in_addra <= word_cnt;
                            in_dina  <= pack_next;
                            word_cnt <= word_cnt + 14'd1;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                        if (final_beat) begin
                            if (!s_last) err_len <= 1'b1;
                            state <= RUN;
                        end else if (s_last) begin
                            err_len <= 1'b1;
                            state   <= IDLE;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
                            w_loaded <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    // First RUN cycle carries the last port-A write, so start rises one cycle later
                    if (start && core_done) begin
                        start     <= 1'b0;
                        load_done <= 1'b1;
                        state     <= FIN;
                    end else begin
                        start <= 1'b1;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_bram_loader.sv
// tb/tb_matmul_bram_loader.sv - scoreboard bench for matmul_bram_loader
module tb_matmul_bram_loader;
    localparam int W   = 6;
    localparam int I   = 3;
    localparam int NC  = 2;
    localparam int BW  = 64;
    localparam int IW  = BW * NC;
    localparam int TOT = W + I * NC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          wb_ena;
    logic [7:0]    wb_wea;
    logic [11:0]   wb_addra;
    logic [BW-1:0] wb_dina;
    logic          in_ena;
    logic [7:0]    in_wea;
    logic [13:0]   in_addra;
    logic [IW-1:0] in_dina;
    logic          start;
    logic          core_done = 1'b0;
    logic          busy;
    logic          load_done;
    logic          err_len;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
    logic          keep_w = 1'b0;
`endif

    matmul_bram_loader dut (
        .clk(clk), .rst_n(rst_n), .go(go),
`ifdef MATLOAD_WEIGHT_RETAIN_EN
        .keep_w(keep_w),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
        .in_ena(in_ena), .in_wea(in_wea), .in_addra(in_addra), .in_dina(in_dina),
        .start(start), .core_done(core_done), .busy(busy),
        .load_done(load_done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cycles = 0;
    int done_pulses = 0;
    logic [11:0]   wq_addr[$];
    logic [BW-1:0] wq_data[$];
    logic [13:0]   iq_addr[$];
    logic [IW-1:0] iq_data[$];

    function automatic void chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expected writes whenever the DUT presents one
    always @(negedge clk) begin
        if (start) start_cycles++;
        if (load_done) done_pulses++;
        if (start) chk("write_during_start", IW'(wb_ena | in_ena), IW'(0));
        if (wb_ena) begin
            chk("wb_wea", IW'(wb_wea), IW'(8'hFF));
            chk("wb_expected", IW'(wq_addr.size() != 0), IW'(1));
            if (wq_addr.size() != 0) begin
                chk("wb_addra", IW'(wb_addra), IW'(wq_addr.pop_front()));
                chk("wb_dina", IW'(wb_dina), IW'(wq_data.pop_front()));
            end
        end
        if (in_ena) begin
            chk("in_wea", IW'(in_wea), IW'(8'hFF));
            chk("in_expected", IW'(iq_addr.size() != 0), IW'(1));
            if (iq_addr.size() != 0) begin
                chk("in_addra", IW'(in_addra), IW'(iq_addr.pop_front()));
                chk("in_dina", in_dina, iq_data.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk({name, "_ctl"}, IW'({s_ready, wb_ena, wb_wea, wb_addra, in_ena, in_wea, in_addra,
                                 start, busy, load_done, err_len}), IW'(0));
        chk({name, "_data"}, IW'(wb_dina) | in_dina, IW'(0));
    endtask

    // last_pos: beat index carrying s_last (-1 = none); reset_at: beat index during which rst_n drops
    task automatic run(input int last_pos, input bit toggle, input bit rnd,
                       input int reset_at, input int done_delay, input bit skip_w);
        logic [BW-1:0] beats[TOT];
        logic [IW-1:0] packed_word;
        int nw, total, n_send, limit, i, g, exp_start;
        bit abort, exp_err, v, rdy;
        nw      = skip_w ? 0 : W;
        total   = nw + I * NC;
        abort   = (last_pos >= 0) && (last_pos != total - 1);
        n_send  = abort ? last_pos + 1 : total;
        limit   = (reset_at >= 0) ? reset_at : n_send;
        exp_err = abort || (last_pos != total - 1);
        for (int k = 0; k < total; k++)
            beats[k] = rnd ? {$urandom, $urandom} : BW'(k + 1);
        for (int k = 0; k < limit; k++) begin
            if (k < nw) begin
                wq_addr.push_back(12'(k));
                wq_data.push_back(beats[k]);
            end else if ((k - nw) % NC == NC - 1) begin
                for (int c = 0; c < NC; c++) packed_word[c*BW +: BW] = beats[k - NC + 1 + c];
                iq_addr.push_back(14'((k - nw) / NC));
                iq_data.push_back(packed_word);
            end
        end
        start_cycles = 0;
        done_pulses  = 0;

        @(posedge clk); #1;
        go = 1'b1;
`ifdef MATLOAD_WEIGHT_RETAIN_EN
        keep_w = skip_w;
`endif
        if (done_delay < 0) core_done = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk("err_len_after_go", IW'(err_len), IW'(0));
        chk("busy_after_go", IW'(busy), IW'(1));

        i = 0;
        g = 0;
        while (i < n_send && g < 2000) begin
            v = toggle ? (g % 2 == 0) : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            s_valid = v;
            s_data  = beats[i];
            s_last  = (i == last_pos);
            rdy     = s_ready;
            if (i == reset_at) rst_n = 1'b0;
            @(posedge clk); #1;
            g++;
            if (i == reset_at) break;
            if (v && rdy) i++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;

        if (reset_at >= 0) begin
            check_all_zero("reset_mid_load");
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("reset_no_start", IW'(start_cycles), IW'(0));
        end else begin
            chk("beats_accepted", IW'(i), IW'(n_send));
            if (abort) begin
                repeat (3) @(posedge clk);
                #1;
                chk("abort_idle", IW'(busy), IW'(0));
            end else begin
                g = 0;
                while (!start && g < 100) begin
                    @(posedge clk); #1;
                    g++;
                end
                chk("start_seen", IW'(start), IW'(1));
                if (done_delay >= 0) begin
                    repeat (done_delay) @(posedge clk);
                    #1;
                    core_done = 1'b1;
                end
                @(posedge clk); #1;
                core_done = 1'b0;
                g = 0;
                while (busy && g < 100) begin
                    @(posedge clk); #1;
                    g++;
                end
                chk("return_idle", IW'(busy), IW'(0));
                @(posedge clk); #1;
            end
            exp_start = abort ? 0 : ((done_delay < 0) ? 1 : done_delay + 1);
            chk("start_cycles", IW'(start_cycles), IW'(exp_start));
            chk("load_done_pulses", IW'(done_pulses), IW'(abort ? 0 : 1));
            chk("err_len", IW'(err_len), IW'(exp_err));
        end
        chk("wb_queue_drained", IW'(wq_addr.size()), IW'(0));
        chk("in_queue_drained", IW'(iq_addr.size()), IW'(0));
        wq_addr.delete(); wq_data.delete(); iq_addr.delete(); iq_data.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;
        run(TOT - 1, 1'b0, 1'b0, -1, 3, 1'b0);
        run(TOT - 1, 1'b1, 1'b0, -1, 0, 1'b0);
        run(3, 1'b0, 1'b0, -1, 0, 1'b0);
        run(TOT - 1, 1'b0, 1'b1, -1, 2, 1'b0);
        run(-1, 1'b0, 1'b0, -1, 1, 1'b0);
        run(TOT - 1, 1'b0, 1'b0, 8, 0, 1'b0);
        run(TOT - 1, 1'b0, 1'b0, -1, 0, 1'b0);
        run(8, 1'b0, 1'b1, -1, 0, 1'b0);
        run(9, 1'b0, 1'b1, -1, 0, 1'b0);
        run(TOT - 1, 1'b0, 1'b1, -1, -1, 1'b0);
        for (int r = 0; r < 4; r++)
            run(TOT - 1, 1'b0, 1'b1, -1, int'($urandom_range(0, 4)), 1'b0);
`ifdef MATLOAD_WEIGHT_RETAIN_EN
        run(I * NC - 1, 1'b0, 1'b1, -1, 1, 1'b1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
